seq_10101_gen: RTL and testbench

SEQ_10101_GEN -- requirements
Module: seq_10101_gen

---
 rtl/seq_10101_gen.sv | 172 +++++++++++++++++
 tb/tb_seq_10101_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_10101_gen.sv
// Serial pattern generator: sends a W-bit pattern MSB first, repeated a
// requested number of times with GAP idle cycles between repetitions.
module seq_10101_gen #(
    parameter int             W           = 5,
    parameter logic [W-1:0]   DEFAULT_PAT = W'(5'b10101),
    parameter int             GAP         = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] pat_in,
    input  logic         use_default,
    input  logic [3:0]   rep_in,
    input  logic         abort,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ready,
    output logic         done
);

    // state | meaning
    // ------+---------------------------------------------------------------
    // IDLE  | ready=1, waiting for start with abort low
    // SEND  | one pattern bit per cycle on ser_out, ser_valid=1
    // GAP   | idle spacing between repetitions, outputs low
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int               IDX_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic             GAP_EN   = (GAP > 0);
    localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       rep_q, rep_d;
    logic [3:0]       gap_q, gap_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    // Outputs are computed for the state being entered so that every
    // output is a flop; shreg_q[W-1] is always the bit currently on the wire.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        gap_d       = gap_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ready_d     = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (start && !abort) begin
                    state_d     = ST_SEND;
                    shreg_d     = use_default ? DEFAULT_PAT : pat_in;
                    idx_d       = IDX_LAST;
                    rep_d       = (rep_in == 4'd0) ? 4'd1 : rep_in;
                    gap_d       = 4'd0;
                    ready_d     = 1'b0;
                    ser_valid_d = 1'b1;
                    ser_out_d   = shreg_d[W-1];
                end
            end

            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    rep_d   = 4'd0;
                    gap_d   = 4'd0;
                    ready_d = 1'b1;
                end else begin
                    // Rotating keeps the pattern intact after W shifts.
                    shreg_d = {shreg_q[W-2:0], shreg_q[W-1]};
                    if (idx_q != '0) begin
                        idx_d       = idx_q - IDX_ONE;
                        ser_valid_d = 1'b1;
                        ser_out_d   = shreg_d[W-1];
                    end else begin
                        rep_d = (rep_q != 4'd0) ? rep_q - 4'd1 : 4'd0;
                        if (rep_q > 4'd1) begin
                            idx_d = IDX_LAST;
                            if (GAP_EN) begin
                                state_d = ST_GAP;
                                gap_d   = GAP_LOAD;
                            end else begin
                                ser_valid_d = 1'b1;
                                ser_out_d   = shreg_d[W-1];
                            end
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    rep_d   = 4'd0;
                    gap_d   = 4'd0;
                    ready_d = 1'b1;
                end else if (gap_q == 4'd0) begin
                    state_d     = ST_SEND;
                    ser_valid_d = 1'b1;
                    ser_out_d   = shreg_q[W-1];
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                idx_d   = '0;
                rep_d   = 4'd0;
                gap_d   = 4'd0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ready     = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_10101_gen.sv
// Bench for seq_10101_gen: two instances (GAP=2 and GAP=0) share stimulus and
// are compared cycle by cycle against an arithmetic model of the output stream.
module tb_seq_10101_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, use_default, abort;
    logic [4:0] pat_in;
    logic [3:0] rep_in;
    logic       out2, val2, rdy2, dn2;
    logic       out0, val0, rdy0, dn0;
    int         n_vec, n_err;

    always #5 clk = ~clk;

    seq_10101_gen #(.W(5), .DEFAULT_PAT(5'b10101), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in),
        .use_default(use_default), .rep_in(rep_in), .abort(abort),
        .ser_out(out2), .ser_valid(val2), .ready(rdy2), .done(dn2)
    );

    seq_10101_gen #(.W(5), .DEFAULT_PAT(5'b10101), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pat_in(pat_in),
        .use_default(use_default), .rep_in(rep_in), .abort(abort),
        .ser_out(out0), .ser_valid(val0), .ready(rdy0), .done(dn0)
    );

    function automatic int busy_of(input int reps, input int g);
        int r;
        r = (reps == 0) ? 1 : reps;
        return r * 5 + (r - 1) * g;
    endfunction

    // Expected {ready,done,valid,out} on cycle k after accept (k>=1).
    // ab>0: abort was high during cycle ab while busy.
    function automatic logic [3:0] exp_at(input logic [4:0] p, input int reps,
                                          input int g, input int k, input int ab);
        int busy, j;
        busy = busy_of(reps, g);
        if (ab > 0 && k > ab) return 4'b1000;
        if (k <= busy) begin
            j = (k - 1) % (5 + g);
            if (j < 5) return {3'b001, p[4 - j]};
            return 4'b0000;
        end
        if (k == busy + 1) return 4'b0100;
        return 4'b1000;
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_vec++;
        if ({rdy2, dn2, val2, out2} !== 4'b1000) begin
            n_err++; $display("FAIL reset_async gap2: got %b want 1000", {rdy2, dn2, val2, out2});
        end
        n_vec++;
        if ({rdy0, dn0, val0, out0} !== 4'b1000) begin
            n_err++; $display("FAIL reset_async gap0: got %b want 1000", {rdy0, dn0, val0, out0});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({rdy2, dn2, val2, out2} !== 4'b1000) begin
            n_err++; $display("FAIL reset_release gap2: got %b want 1000", {rdy2, dn2, val2, out2});
        end
    endtask

    task automatic test_directed();
        logic [4:0] pats [4];
        logic       defs [4];
        logic [3:0] reps [4];
        logic [4:0] p;
        logic [3:0] e2, e0;
        int         span;
        pats = '{5'b01110, 5'b11001, 5'b00011, 5'b01000};
        defs = '{1'b1, 1'b0, 1'b1, 1'b1};
        reps = '{4'd1, 4'd2, 4'd0, 4'd3};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b1; pat_in = pats[c]; use_default = defs[c];
            rep_in = reps[c]; abort = 1'b0;
            p = defs[c] ? 5'b10101 : pats[c];
            span = busy_of(reps[c], 2) + 2;
            for (int k = 1; k <= span; k++) begin
                @(negedge clk);
                e2 = exp_at(p, reps[c], 2, k, 0);
                e0 = exp_at(p, reps[c], 0, k, 0);
                n_vec++;
                if ({rdy2, dn2, val2, out2} !== e2) begin
                    n_err++; $display("FAIL directed%0d k=%0d gap2 {rdy,done,vld,out}: got %b want %b", c, k, {rdy2, dn2, val2, out2}, e2);
                end
                n_vec++;
                if ({rdy0, dn0, val0, out0} !== e0) begin
                    n_err++; $display("FAIL directed%0d k=%0d gap0 {rdy,done,vld,out}: got %b want %b", c, k, {rdy0, dn0, val0, out0}, e0);
                end
                start = 1'b0; pat_in = 5'($urandom);
                use_default = 1'($urandom); rep_in = 4'($urandom);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] reps [4];
        int         ab_drv [4];
        int         ab_mdl [4];
        logic [3:0] e2, e0;
        int         span;
        reps   = '{4'd2, 4'd2, 4'd1, 4'd1};
        ab_drv = '{3, 6, 6, 0};
        ab_mdl = '{3, 6, 0, 0};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 1'b1; use_default = 1'b1; rep_in = reps[c]; abort = 1'b0;
            span = (ab_mdl[c] > 0) ? ab_mdl[c] + 2 : busy_of(reps[c], 2) + 2;
            for (int k = 1; k <= span; k++) begin
                @(negedge clk);
                e2 = exp_at(5'b10101, reps[c], 2, k, ab_mdl[c]);
                e0 = exp_at(5'b10101, reps[c], 0, k, ab_mdl[c]);
                n_vec++;
                if ({rdy2, dn2, val2, out2} !== e2) begin
                    n_err++; $display("FAIL abort%0d k=%0d gap2 {rdy,done,vld,out}: got %b want %b", c, k, {rdy2, dn2, val2, out2}, e2);
                end
                n_vec++;
                if ({rdy0, dn0, val0, out0} !== e0) begin
                    n_err++; $display("FAIL abort%0d k=%0d gap0 {rdy,done,vld,out}: got %b want %b", c, k, {rdy0, dn0, val0, out0}, e0);
                end
                start = 1'b0;
                abort = (k == ab_drv[c]);
            end
            abort = 1'b0;
        end
    endtask

    task automatic test_ignore_start();
        logic [3:0] e2, e0;
        int         span, lim;
        @(negedge clk);
        start = 1'b1; pat_in = 5'b11001; use_default = 1'b0; rep_in = 4'd2; abort = 1'b0;
        lim  = busy_of(2, 0) + 1;
        span = busy_of(2, 2) + 2;
        for (int k = 1; k <= span; k++) begin
            @(negedge clk);
            e2 = exp_at(5'b11001, 2, 2, k, 0);
            e0 = exp_at(5'b11001, 2, 0, k, 0);
            n_vec++;
            if ({rdy2, dn2, val2, out2} !== e2) begin
                n_err++; $display("FAIL busy_start k=%0d gap2 {rdy,done,vld,out}: got %b want %b", k, {rdy2, dn2, val2, out2}, e2);
            end
            n_vec++;
            if ({rdy0, dn0, val0, out0} !== e0) begin
                n_err++; $display("FAIL busy_start k=%0d gap0 {rdy,done,vld,out}: got %b want %b", k, {rdy0, dn0, val0, out0}, e0);
            end
            start = (k <= lim);
            pat_in = 5'($urandom); rep_in = 4'($urandom);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1; abort = 1'b1;
            @(negedge clk);
            n_vec++;
            if ({rdy2, dn2, val2, out2, rdy0, dn0, val0, out0} !== 8'b1000_1000) begin
                n_err++; $display("FAIL start_with_abort k=%0d: got %b want 10001000", k, {rdy2, dn2, val2, out2, rdy0, dn0, val0, out0});
            end
            start = 1'b0; abort = 1'b0;
        end
    endtask

    task automatic test_rst_mid_gap();
        logic [3:0] e2, e0;
        @(negedge clk);
        start = 1'b1; use_default = 1'b1; rep_in = 4'd2; abort = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e2 = exp_at(5'b10101, 2, 2, k, 0);
            e0 = exp_at(5'b10101, 2, 0, k, 0);
            n_vec++;
            if ({rdy2, dn2, val2, out2} !== e2) begin
                n_err++; $display("FAIL pre_rst k=%0d gap2 {rdy,done,vld,out}: got %b want %b", k, {rdy2, dn2, val2, out2}, e2);
            end
            n_vec++;
            if ({rdy0, dn0, val0, out0} !== e0) begin
                n_err++; $display("FAIL pre_rst k=%0d gap0 {rdy,done,vld,out}: got %b want %b", k, {rdy0, dn0, val0, out0}, e0);
            end
            start = (k == 2);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({rdy2, dn2, val2, out2, rdy0, dn0, val0, out0} !== 8'b1000_1000) begin
            n_err++; $display("FAIL rst_mid_gap async: got %b want 10001000", {rdy2, dn2, val2, out2, rdy0, dn0, val0, out0});
        end
        @(negedge clk);
        n_vec++;
        if ({rdy2, dn2, val2, out2, rdy0, dn0, val0, out0} !== 8'b1000_1000) begin
            n_err++; $display("FAIL rst_mid_gap held: got %b want 10001000", {rdy2, dn2, val2, out2, rdy0, dn0, val0, out0});
        end
        rst = 1'b0;
        start = 1'b1; use_default = 1'b1; rep_in = 4'd1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            e2 = exp_at(5'b10101, 1, 2, k, 0);
            e0 = exp_at(5'b10101, 1, 0, k, 0);
            n_vec++;
            if ({rdy2, dn2, val2, out2} !== e2) begin
                n_err++; $display("FAIL post_rst k=%0d gap2 {rdy,done,vld,out}: got %b want %b", k, {rdy2, dn2, val2, out2}, e2);
            end
            n_vec++;
            if ({rdy0, dn0, val0, out0} !== e0) begin
                n_err++; $display("FAIL post_rst k=%0d gap0 {rdy,done,vld,out}: got %b want %b", k, {rdy0, dn0, val0, out0}, e0);
            end
            start = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [4:0] pv, p;
        logic       ud;
        logic [3:0] rv;
        logic [3:0] e2, e0;
        int         b0, b2, ab, lim, span;
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            pv = 5'($urandom); ud = 1'($urandom); rv = 4'($urandom);
            p  = ud ? 5'b10101 : pv;
            b0 = busy_of(rv, 0);
            b2 = busy_of(rv, 2);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, b0)) : 0;
            lim  = (ab > 0) ? ab : b0 + 1;
            span = (ab > 0) ? ab + 2 : b2 + 2;
            start = 1'b1; pat_in = pv; use_default = ud; rep_in = rv; abort = 1'b0;
            for (int k = 1; k <= span; k++) begin
                @(negedge clk);
                e2 = exp_at(p, rv, 2, k, ab);
                e0 = exp_at(p, rv, 0, k, ab);
                n_vec++;
                if ({rdy2, dn2, val2, out2} !== e2) begin
                    n_err++; $display("FAIL random%0d k=%0d gap2 {rdy,done,vld,out}: got %b want %b", it, k, {rdy2, dn2, val2, out2}, e2);
                end
                n_vec++;
                if ({rdy0, dn0, val0, out0} !== e0) begin
                    n_err++; $display("FAIL random%0d k=%0d gap0 {rdy,done,vld,out}: got %b want %b", it, k, {rdy0, dn0, val0, out0}, e0);
                end
                start = (k <= lim) ? 1'($urandom) : 1'b0;
                abort = (k == ab);
                pat_in = 5'($urandom); use_default = 1'($urandom); rep_in = 4'($urandom);
            end
            start = 1'b0; abort = 1'b0;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        start = 1'b0; abort = 1'b0; use_default = 1'b0;
        pat_in = 5'd0; rep_in = 4'd0;
        test_reset();
        test_directed();
        test_abort();
        test_ignore_start();
        test_rst_mid_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
